// File: rtl/ddr_frame_writer.sv
// Drains a FWFT pixel FIFO into one of four DDR frame buffers as fixed-length AXI4 INCR bursts.
// Optional per-frame cycle counter is built when DDR_WR_PERF_CNT_EN is defined.
module ddr_frame_writer #(
  parameter logic [31:0] BASE_ADDR   = 32'h8000_0000,
  parameter int          FRAME_WORDS = 262144,
  parameter int          BURST_LEN   = 64
) (
  input  logic        aclk,
  input  logic        aresetn,
  input  logic        enable,
  input  logic        frame_store,
  input  logic [1:0]  frame_type_i,
  input  logic [31:0] fifo_rddata,
  input  logic [15:0] fifo_rd_count,
  output logic        fifo_rden,
  output logic [31:0] m_axi_awaddr,
  output logic [7:0]  m_axi_awlen,
  output logic [2:0]  m_axi_awsize,
  output logic [1:0]  m_axi_awburst,
  output logic        m_axi_awvalid,
  input  logic        m_axi_awready,
  output logic [31:0] m_axi_wdata,
  output logic [3:0]  m_axi_wstrb,
  output logic        m_axi_wlast,
  output logic        m_axi_wvalid,
  input  logic        m_axi_wready,
  input  logic [1:0]  m_axi_bresp,
  input  logic        m_axi_bvalid,
  output logic        m_axi_bready,
  output logic        frame_done,
  output logic [1:0]  frame_type_o,
  output logic        wr_err,
  output logic        frame_overrun,
  output logic [31:0] frame_cycles
);

  localparam logic [7:0]  LP_LAST_BEAT   = 8'(BURST_LEN - 1);
  localparam logic [15:0] LP_BURST_WORDS = 16'(BURST_LEN);
  localparam logic [31:0] LP_BURST_BYTES = 32'(BURST_LEN * 4);
  localparam logic [31:0] LP_STRIDE      = 32'(FRAME_WORDS * 4);
  localparam logic [31:0] LP_NUM_BURSTS  = 32'(FRAME_WORDS / BURST_LEN);

  typedef enum logic [2:0] {
    ST_IDLE      = 3'd0,
    ST_WAIT_DATA = 3'd1,
    ST_AW        = 3'd2,
    ST_W         = 3'd3,
    ST_B         = 3'd4,
    ST_DONE      = 3'd5
  } state_t;

  state_t      r_state;
  state_t      w_state_nxt;

  logic        r_slot_vld;
  logic [1:0]  r_slot_type;
  logic [1:0]  r_cur_type;
  logic [31:0] r_addr;
  logic [31:0] r_burst_cnt;
  logic [7:0]  r_beat;

  logic        r_awvalid;
  logic [31:0] r_awaddr;
  logic [7:0]  r_awlen;
  logic        r_wvalid;
  logic        r_wlast;
  logic        r_bready;
  logic        r_frame_done;
  logic [1:0]  r_frame_type_o;
  logic        r_wr_err;
  logic        r_overrun;

  logic        w_store;
  logic        w_consume;
  logic        w_beat_acc;
  logic        w_b_acc;
  logic        w_last_burst;
  logic [7:0]  w_beat_nxt;
  logic [31:0] w_frame_base;

  assign w_store      = frame_store & enable;
  assign w_beat_acc   = r_wvalid & m_axi_wready;
  assign w_b_acc      = r_bready & m_axi_bvalid;
  assign w_last_burst = ((r_burst_cnt + 32'd1) == LP_NUM_BURSTS);

  // State register
  always_ff @(posedge aclk) begin
    if (!aresetn) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // Next-state logic; slot consumption only happens from IDLE
  always_comb begin
    w_state_nxt = r_state;
    w_consume   = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (r_slot_vld) begin
          w_state_nxt = ST_WAIT_DATA;
          w_consume   = 1'b1;
        end else begin
          w_state_nxt = ST_IDLE;
        end
      end
      ST_WAIT_DATA: begin
        if (fifo_rd_count >= LP_BURST_WORDS) begin
          w_state_nxt = ST_AW;
        end else begin
          w_state_nxt = ST_WAIT_DATA;
        end
      end
      ST_AW: begin
        if (m_axi_awready) begin
          w_state_nxt = ST_W;
        end else begin
          w_state_nxt = ST_AW;
        end
      end
      ST_W: begin
        if (w_beat_acc && (r_beat == LP_LAST_BEAT)) begin
          w_state_nxt = ST_B;
        end else begin
          w_state_nxt = ST_W;
        end
      end
      ST_B: begin
        if (w_b_acc) begin
          w_state_nxt = w_last_burst ? ST_DONE : ST_WAIT_DATA;
        end else begin
          w_state_nxt = ST_B;
        end
      end
      ST_DONE: begin
        w_state_nxt = ST_IDLE;
      end
      default: begin
        w_state_nxt = ST_IDLE;
      end
    endcase
  end

  // Beat index of the next W cycle; wlast is registered from it
  always_comb begin
    if (r_state == ST_AW) begin
      w_beat_nxt = 8'd0;
    end else if (w_beat_acc) begin
      w_beat_nxt = r_beat + 8'd1;
    end else begin
      w_beat_nxt = r_beat;
    end
  end

  // Frame buffer base address for the pending slot's type
  always_comb begin
    case (r_slot_type)
      2'd0:    w_frame_base = BASE_ADDR;
      2'd1:    w_frame_base = BASE_ADDR + LP_STRIDE;
      2'd2:    w_frame_base = BASE_ADDR + (LP_STRIDE * 32'd2);
      2'd3:    w_frame_base = BASE_ADDR + (LP_STRIDE * 32'd3);
      default: w_frame_base = BASE_ADDR;
    endcase
  end

  // Registered AXI and status outputs, decoded from the next state
  always_ff @(posedge aclk) begin
    if (!aresetn) begin
      r_awvalid      <= 1'b0;
      r_awaddr       <= 32'h0;
      r_awlen        <= 8'h0;
      r_wvalid       <= 1'b0;
      r_wlast        <= 1'b0;
      r_bready       <= 1'b0;
      r_frame_done   <= 1'b0;
      r_frame_type_o <= 2'b00;
    end else begin
      r_awvalid      <= (w_state_nxt == ST_AW);
      r_awaddr       <= (w_state_nxt == ST_AW) ? r_addr : 32'h0;
      r_awlen        <= (w_state_nxt == ST_AW) ? LP_LAST_BEAT : 8'h0;
      r_wvalid       <= (w_state_nxt == ST_W);
      r_wlast        <= (w_state_nxt == ST_W) && (w_beat_nxt == LP_LAST_BEAT);
      r_bready       <= (w_state_nxt == ST_B);
      r_frame_done   <= (w_state_nxt == ST_DONE);
      r_frame_type_o <= (w_state_nxt == ST_DONE) ? r_cur_type : 2'b00;
    end
  end

  // Frame datapath: address, burst/beat counters, error flag
  always_ff @(posedge aclk) begin
    if (!aresetn) begin
      r_cur_type  <= 2'b00;
      r_addr      <= 32'h0;
      r_burst_cnt <= 32'h0;
      r_beat      <= 8'h0;
      r_wr_err    <= 1'b0;
    end else begin
      if (w_consume) begin
        r_cur_type  <= r_slot_type;
        r_addr      <= w_frame_base;
        r_burst_cnt <= 32'h0;
      end else if (w_b_acc) begin
        r_addr      <= r_addr + LP_BURST_BYTES;
        r_burst_cnt <= r_burst_cnt + 32'd1;
      end
      r_beat <= w_beat_nxt;
      if (w_b_acc && (m_axi_bresp != 2'b00)) begin
        r_wr_err <= 1'b1;
      end
    end
  end

  // Pending slot; a store coinciding with consumption refills the freed slot
  always_ff @(posedge aclk) begin
    if (!aresetn) begin
      r_slot_vld  <= 1'b0;
      r_slot_type <= 2'b00;
      r_overrun   <= 1'b0;
    end else begin
      if (w_consume) begin
        r_slot_vld <= w_store;
        if (w_store) begin
          r_slot_type <= frame_type_i;
        end
      end else if (w_store) begin
        if (r_slot_vld) begin
          r_overrun <= 1'b1;
        end else begin
          r_slot_vld  <= 1'b1;
          r_slot_type <= frame_type_i;
        end
      end
    end
  end

`ifdef DDR_WR_PERF_CNT_EN
  logic [31:0] r_perf_cnt;
  logic [31:0] r_frame_cycles;

  // Saturating frame-duration counter, published in DONE
  always_ff @(posedge aclk) begin
    if (!aresetn) begin
      r_perf_cnt     <= 32'h0;
      r_frame_cycles <= 32'h0;
    end else begin
      if (w_consume) begin
        r_perf_cnt <= 32'h0;
      end else if ((r_state inside {ST_WAIT_DATA, ST_AW, ST_W, ST_B}) &&
                   (r_perf_cnt != 32'hFFFF_FFFF)) begin
        r_perf_cnt <= r_perf_cnt + 32'd1;
      end
      if (r_state == ST_DONE) begin
        r_frame_cycles <= r_perf_cnt;
      end
    end
  end

  assign frame_cycles = r_frame_cycles;
`else
  assign frame_cycles = 32'h0;
`endif

  assign fifo_rden     = r_wvalid & m_axi_wready;
  assign m_axi_awaddr  = r_awaddr;
  assign m_axi_awlen   = r_awlen;
  assign m_axi_awsize  = 3'b010;
  assign m_axi_awburst = 2'b01;
  assign m_axi_awvalid = r_awvalid;
  assign m_axi_wdata   = r_wvalid ? fifo_rddata : 32'h0;
  assign m_axi_wstrb   = 4'hF;
  assign m_axi_wlast   = r_wlast;
  assign m_axi_wvalid  = r_wvalid;
  assign m_axi_bready  = r_bready;
  assign frame_done    = r_frame_done;
  assign frame_type_o  = r_frame_type_o;
  assign wr_err        = r_wr_err;
  assign frame_overrun = r_overrun;

endmodule

// File: tb/tb_ddr_frame_writer.sv
// Directed bench for ddr_frame_writer: FWFT FIFO model, AXI slave responder and burst monitor.
module tb_ddr_frame_writer;

  logic        aclk = 1'b0;
  logic        aresetn;
  logic        enable;
  logic        frame_store;
  logic [1:0]  frame_type_i;
  logic [31:0] fifo_rddata;
  logic [15:0] fifo_rd_count;
  logic        fifo_rden;
  logic [31:0] m_axi_awaddr;
  logic [7:0]  m_axi_awlen;
  logic [2:0]  m_axi_awsize;
  logic [1:0]  m_axi_awburst;
  logic        m_axi_awvalid;
  logic        m_axi_awready;
  logic [31:0] m_axi_wdata;
  logic [3:0]  m_axi_wstrb;
  logic        m_axi_wlast;
  logic        m_axi_wvalid;
  logic        m_axi_wready;
  logic [1:0]  m_axi_bresp;
  logic        m_axi_bvalid;
  logic        m_axi_bready;
  logic        frame_done;
  logic [1:0]  frame_type_o;
  logic        wr_err;
  logic        frame_overrun;
  logic [31:0] frame_cycles;

  always #5 aclk = ~aclk;

  ddr_frame_writer #(
    .BASE_ADDR  (32'h0),
    .FRAME_WORDS(256),
    .BURST_LEN  (64)
  ) dut (
    .aclk(aclk), .aresetn(aresetn), .enable(enable), .frame_store(frame_store),
    .frame_type_i(frame_type_i), .fifo_rddata(fifo_rddata), .fifo_rd_count(fifo_rd_count),
    .fifo_rden(fifo_rden), .m_axi_awaddr(m_axi_awaddr), .m_axi_awlen(m_axi_awlen),
    .m_axi_awsize(m_axi_awsize), .m_axi_awburst(m_axi_awburst), .m_axi_awvalid(m_axi_awvalid),
    .m_axi_awready(m_axi_awready), .m_axi_wdata(m_axi_wdata), .m_axi_wstrb(m_axi_wstrb),
    .m_axi_wlast(m_axi_wlast), .m_axi_wvalid(m_axi_wvalid), .m_axi_wready(m_axi_wready),
    .m_axi_bresp(m_axi_bresp), .m_axi_bvalid(m_axi_bvalid), .m_axi_bready(m_axi_bready),
    .frame_done(frame_done), .frame_type_o(frame_type_o), .wr_err(wr_err),
    .frame_overrun(frame_overrun), .frame_cycles(frame_cycles)
  );

  // Written only by the main stimulus process
  int push_total  = 0;
  bit wready_rand = 1'b0;
  int err_at      = -1;

  // Written only by the bus model
  logic [31:0] fifo_q[$];
  logic [31:0] next_val = 32'hA000_0000;
  logic [31:0] exp_val  = 32'hA000_0000;
  int          pushed = 0;
  bit          in_burst = 1'b0;
  bit          b_pend = 1'b0;
  int          beat_idx = 0;
  int          beat_total = 0;
  int          b_total = 0;
  int          aw_cnt = 0;
  int          done_cnt = 0;
  int          early_bad = 0;
  int          wdrop_bad = 0;
  int          wlast_bad = 0;
  int          awlen_bad = 0;
  int          data_bad = 0;
  logic [31:0] aw_log [0:63];
  logic [1:0]  done_log [0:15];
  bit          s_rst;
  bit          s_pop;
  bit          s_b;

  int n_total = 0;
  int n_bad   = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_total++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h want %0h", tag, obs, exp);
    end
  endtask

  // FIFO, AXI slave and burst monitor: observe at negedge, respond just after posedge
  initial begin : bus_model
    m_axi_awready = 1'b1;
    m_axi_wready  = 1'b1;
    m_axi_bvalid  = 1'b0;
    m_axi_bresp   = 2'b00;
    fifo_rddata   = 32'h0;
    fifo_rd_count = 16'h0;
    forever begin
      @(negedge aclk);
      s_rst = !aresetn;
      s_pop = fifo_rden;
      s_b   = m_axi_bvalid & m_axi_bready;
      if (aresetn) begin
        if (m_axi_awvalid && (fifo_rd_count < 16'd64)) early_bad++;
        if (m_axi_wvalid != in_burst) wdrop_bad++;
        if (m_axi_wvalid && (m_axi_wlast != (beat_idx == 63))) wlast_bad++;
        if (m_axi_awvalid && m_axi_awready) begin
          if (aw_cnt < 64) aw_log[aw_cnt] = m_axi_awaddr;
          if (m_axi_awlen != 8'd63) awlen_bad++;
          aw_cnt++;
          in_burst = 1'b1;
          beat_idx = 0;
        end
        if (m_axi_wvalid && m_axi_wready) begin
          if (m_axi_wdata != exp_val) data_bad++;
          exp_val = exp_val + 32'd1;
          beat_total++;
          beat_idx++;
          if (beat_idx == 64) begin
            in_burst = 1'b0;
            b_pend   = 1'b1;
          end
        end
        if (frame_done) begin
          if (done_cnt < 16) done_log[done_cnt] = frame_type_o;
          done_cnt++;
        end
      end
      @(posedge aclk);
      #1;
      if (s_rst) begin
        fifo_q.delete();
        pushed       = push_total;
        exp_val      = next_val;
        in_burst     = 1'b0;
        beat_idx     = 0;
        b_pend       = 1'b0;
        m_axi_bvalid = 1'b0;
      end else begin
        if (s_pop && (fifo_q.size() > 0)) void'(fifo_q.pop_front());
        if (s_b) m_axi_bvalid = 1'b0;
        if (b_pend) begin
          m_axi_bvalid = 1'b1;
          m_axi_bresp  = (b_total == err_at) ? 2'b10 : 2'b00;
          b_total++;
          b_pend = 1'b0;
        end
      end
      while (pushed < push_total) begin
        fifo_q.push_back(next_val);
        next_val = next_val + 32'd1;
        pushed++;
      end
      fifo_rddata   = (fifo_q.size() > 0) ? fifo_q[0] : 32'h0;
      fifo_rd_count = 16'(fifo_q.size());
      m_axi_wready  = wready_rand ? 1'($urandom_range(0, 1)) : 1'b1;
    end
  end

  task automatic tick();
    @(posedge aclk);
    #2;
  endtask

  task automatic pulse_store(input logic en, input logic [1:0] t);
    enable       = en;
    frame_type_i = t;
    frame_store  = 1'b1;
    tick();
    frame_store  = 1'b0;
    enable       = 1'b1;
  endtask

  task automatic wait_done(input int target, input int bound);
    int n = 0;
    while ((done_cnt < target) && (n < bound)) begin
      tick();
      n++;
    end
    check("done_count", 32'(done_cnt), 32'(target));
  endtask

  task automatic check_bursts(input string tag, input int first, input logic [31:0] base);
    for (int i = 0; i < 4; i++) begin
      check(tag, aw_log[first + i], base + 32'(i * 256));
    end
  endtask

  task automatic check_clean();
    check("awlen_bad", 32'(awlen_bad), 32'd0);
    check("data_bad", 32'(data_bad), 32'd0);
    check("wlast_bad", 32'(wlast_bad), 32'd0);
    check("wvalid_drop", 32'(wdrop_bad), 32'd0);
    check("early_aw", 32'(early_bad), 32'd0);
  endtask

  initial begin : main
    int lat;
    int n;
    int base_aw;
    int base_done;
    aresetn      = 1'b0;
    enable       = 1'b0;
    frame_store  = 1'b0;
    frame_type_i = 2'b00;
    repeat (4) tick();

    // Reset state
    check("rst_ctl", {24'h0, m_axi_awvalid, m_axi_wvalid, m_axi_wlast, m_axi_bready,
                      fifo_rden, frame_done, wr_err, frame_overrun}, 32'h0);
    check("rst_awaddr", m_axi_awaddr, 32'h0);
    check("rst_awlen", {24'h0, m_axi_awlen}, 32'h0);
    check("rst_fixed", {23'h0, m_axi_awsize, m_axi_awburst, m_axi_wstrb}, {23'h0, 3'b010, 2'b01, 4'hF});
    check("rst_cycles", frame_cycles, 32'h0);
    aresetn = 1'b1;
    tick();

    // Frame 1: type 2, prefilled FIFO, always-ready slave
    push_total += 256;
    repeat (3) tick();
    pulse_store(1'b0, 2'd2);
    repeat (10) tick();
    check("en_low_no_aw", 32'(aw_cnt), 32'd0);
    check("en_low_no_ovr", {31'h0, frame_overrun}, 32'd0);
    enable       = 1'b1;
    frame_type_i = 2'd2;
    frame_store  = 1'b1;
    tick();
    frame_store  = 1'b0;
    lat = 1;
    while (!m_axi_awvalid && (lat < 20)) begin
      tick();
      lat++;
    end
    check("store_to_awvalid", 32'(lat), 32'd3);
    check("first_awaddr", m_axi_awaddr, 32'h800);
    wait_done(1, 3000);
    check("f1_aw_cnt", 32'(aw_cnt), 32'd4);
    check_bursts("f1_awaddr", 0, 32'h800);
    check("f1_type", {30'h0, done_log[0]}, 32'd2);
    check("f1_beats", 32'(beat_total), 32'd256);
    check("f1_fifo_empty", {16'h0, fifo_rd_count}, 32'd0);
    check("f1_flags", {30'h0, wr_err, frame_overrun}, 32'd0);
`ifndef DDR_WR_PERF_CNT_EN
    check("f1_cycles", frame_cycles, 32'h0);
`else
    check("f1_cycles_nz", {31'h0, (frame_cycles != 32'h0)}, 32'd1);
`endif
    check_clean();

    // Frame 2: type 1, FIFO trickle-filled at one word per four cycles
    pulse_store(1'b1, 2'd1);
    for (int i = 0; i < 256; i++) begin
      push_total += 1;
      repeat (4) tick();
      if (i == 62) check("no_aw_below_64", 32'(aw_cnt), 32'd4);
    end
    wait_done(2, 3000);
    check_bursts("f2_awaddr", 4, 32'h400);
    check("f2_type", {30'h0, done_log[1]}, 32'd1);
    check_clean();

    // Frames 3/4: random wready, SLVERR on burst 2, overrun pulses mid-frame
    wready_rand = 1'b1;
    err_at      = b_total + 1;
    push_total += 512;
    repeat (3) tick();
    base_aw = aw_cnt;
    pulse_store(1'b1, 2'd3);
    n = 0;
    while ((aw_cnt <= base_aw) && (n < 100)) begin
      tick();
      n++;
    end
    pulse_store(1'b1, 2'd0);
    check("ovr_after_first", {31'h0, frame_overrun}, 32'd0);
    tick();
    pulse_store(1'b1, 2'd1);
    check("ovr_after_second", {31'h0, frame_overrun}, 32'd1);
    tick();
    pulse_store(1'b1, 2'd1);
    wait_done(4, 8000);
    repeat (200) tick();
    check("f34_no_extra", 32'(done_cnt), 32'd4);
    check("f34_aw_cnt", 32'(aw_cnt), 32'd16);
    check_bursts("f3_awaddr", 8, 32'hC00);
    check_bursts("f4_awaddr", 12, 32'h000);
    check("f3_type", {30'h0, done_log[2]}, 32'd3);
    check("f4_type", {30'h0, done_log[3]}, 32'd0);
    check("wr_err_sticky", {31'h0, wr_err}, 32'd1);
    check("ovr_sticky", {31'h0, frame_overrun}, 32'd1);
    check("f34_beats", 32'(beat_total), 32'd1024);
    check_clean();

    // Reset during beat 10 of the first burst, then a clean frame
    wready_rand = 1'b0;
    push_total += 256;
    repeat (3) tick();
    pulse_store(1'b1, 2'd1);
    n = 0;
    while (!(in_burst && (beat_idx >= 10)) && (n < 300)) begin
      tick();
      n++;
    end
    check("reached_beat10", {31'h0, in_burst}, 32'd1);
    aresetn = 1'b0;
    tick();
    check("mid_rst_ctl", {24'h0, m_axi_awvalid, m_axi_wvalid, m_axi_wlast, m_axi_bready,
                          fifo_rden, frame_done, wr_err, frame_overrun}, 32'h0);
    check("mid_rst_wdata", m_axi_wdata, 32'h0);
    check("mid_rst_cycles", frame_cycles, 32'h0);
    tick();
    aresetn = 1'b1;
    repeat (2) tick();
    base_aw   = aw_cnt;
    base_done = done_cnt;
    push_total += 256;
    repeat (3) tick();
    pulse_store(1'b1, 2'd1);
    wait_done(base_done + 1, 3000);
    check("post_rst_awaddr", aw_log[base_aw], 32'h400);
    check("post_rst_type", {30'h0, done_log[base_done]}, 32'd1);
    check("post_rst_flags", {30'h0, wr_err, frame_overrun}, 32'd0);
`ifndef DDR_WR_PERF_CNT_EN
    check("post_rst_cycles", frame_cycles, 32'h0);
`endif
    check_clean();

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule
